// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: AXI encodings, line geometry and the
// write-back engine state type.
package cc_pkg;

  localparam int LINE_BEATS = 8;
  localparam int BEAT_W     = 64;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef logic [511:0] line_t;

  typedef enum logic [1:0] {
    WB_IDLE = 2'b00,
    WB_ADDR = 2'b01,
    WB_DATA = 2'b10,
    WB_RESP = 2'b11
  } wb_state_t;

  // Line tag: address with the 64-byte offset stripped.
  function automatic logic [25:0] line_tag(input logic [31:0] addr);
    return addr[31:6];
  endfunction

endpackage

// File: rtl/cc_wb_serializer.sv
// Holds one evicted line and presents it as 64-bit beats, word 0 first.
// The FSM loads the line on accept and advances once per accepted W beat.
module cc_wb_serializer
  import cc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  line_t       line_i,
  input  logic        advance_i,
  output logic [63:0] word_o,
  output logic        last_o
);

  line_t      line_q;
  line_t      line_d;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  // Next-state: a load restarts at word 0, an advance steps (3-bit wrap).
  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      line_d = line_i;
      cnt_d  = 3'd0;
    end else if (advance_i) begin
      cnt_d = cnt_q + 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Line buffer and beat counter; cleared so wdata reads 0 after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_q <= '0;
      cnt_q  <= 3'd0;
    end else begin
      line_q <= line_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o = line_q[{cnt_q, 6'd0} +: 64];
  assign last_o = (cnt_q == 3'(LINE_BEATS - 1));

endmodule

// File: rtl/cc_writeback_unit.sv
// Write-back engine: takes one dirty line and emits a single AXI INCR burst
// (AW, eight 64-bit W beats, B), then pulses done (and err on a bad bresp).
module cc_writeback_unit
  import cc_pkg::*;
#(
  parameter int LINE_BEATS = cc_pkg::LINE_BEATS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wb_req_valid_i,
  output logic         wb_req_ready_o,
  input  logic [31:0]  wb_addr_i,
  input  logic [511:0] wb_data_i,
  output logic         wb_busy_o,
  output logic [25:0]  wb_pend_addr_o,
  output logic         wb_done_o,
  output logic         wb_err_o,
  output logic [31:0]  awaddr_o,
  output logic [3:0]   awlen_o,
  output logic [2:0]   awsize_o,
  output logic [1:0]   awburst_o,
  output logic         awvalid_o,
  input  logic         awready_i,
  output logic [63:0]  wdata_o,
  output logic [7:0]   wstrb_o,
  output logic         wlast_o,
  output logic         wvalid_o,
  input  logic         wready_i,
  input  logic [1:0]   bresp_i,
  input  logic         bvalid_i,
  output logic         bready_o
);

  wb_state_t   state_q;
  logic        req_ready_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        done_q;
  logic        err_q;
  logic [25:0] pend_q;

  logic        load_s;
  logic        advance_s;
  logic        last_s;
  logic [63:0] word_s;
  logic        addr_offset_unused_s;

  // Offset bits of the line address carry no information for a full-line write.
  assign addr_offset_unused_s = ^wb_addr_i[5:0];

  assign load_s    = req_ready_q & wb_req_valid_i;
  assign advance_s = wvalid_q & wready_i;

  cc_wb_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load_s),
    .line_i    (wb_data_i),
    .advance_i (advance_s),
    .word_o    (word_s),
    .last_o    (last_s)
  );

  // Burst sequencer; every handshake-visible output is a flop set here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= WB_IDLE;
      req_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pend_q      <= 26'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        WB_IDLE: begin
          if (load_s) begin
            state_q     <= WB_ADDR;
            req_ready_q <= 1'b0;
            awvalid_q   <= 1'b1;
            pend_q      <= line_tag(wb_addr_i);
          end
        end
        WB_ADDR: begin
          if (awready_i) begin
            state_q   <= WB_DATA;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
          end
        end
        WB_DATA: begin
          if (advance_s && last_s) begin
            state_q  <= WB_RESP;
            wvalid_q <= 1'b0;
            bready_q <= 1'b1;
          end
        end
        WB_RESP: begin
          if (bvalid_i) begin
            state_q     <= WB_IDLE;
            bready_q    <= 1'b0;
            req_ready_q <= 1'b1;
            done_q      <= 1'b1;
            err_q       <= (bresp_i != RESP_OKAY);
            pend_q      <= 26'd0;
          end
        end
        default: begin
          state_q     <= WB_IDLE;
          req_ready_q <= 1'b1;
          awvalid_q   <= 1'b0;
          wvalid_q    <= 1'b0;
          bready_q    <= 1'b0;
          pend_q      <= 26'd0;
        end
      endcase
    end
  end

  assign wb_req_ready_o = req_ready_q;
  assign wb_busy_o      = (state_q != WB_IDLE);
  assign wb_pend_addr_o = pend_q;
  assign wb_done_o      = done_q;
  assign wb_err_o       = err_q;

  assign awaddr_o  = {pend_q, 6'd0};
  assign awlen_o   = 4'(LINE_BEATS - 1);
  assign awsize_o  = SIZE_8B;
  assign awburst_o = BURST_INCR;
  assign awvalid_o = awvalid_q;

  assign wdata_o  = word_s;
  assign wstrb_o  = wvalid_q ? 8'hFF : 8'h00;
  assign wlast_o  = wvalid_q & last_s;
  assign wvalid_o = wvalid_q;

  assign bready_o = bready_q;

endmodule

// File: tb/tb_cc_writeback_unit.sv
// Self-checking bench for cc_writeback_unit: directed scenarios plus
// randomized bursts, each checked against a line/beat reference model.
module tb_cc_writeback_unit;
  import cc_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wb_req_valid_i;
  logic         wb_req_ready_o;
  logic [31:0]  wb_addr_i;
  logic [511:0] wb_data_i;
  logic         wb_busy_o;
  logic [25:0]  wb_pend_addr_o;
  logic         wb_done_o;
  logic         wb_err_o;
  logic [31:0]  awaddr_o;
  logic [3:0]   awlen_o;
  logic [2:0]   awsize_o;
  logic [1:0]   awburst_o;
  logic         awvalid_o;
  logic         awready_i;
  logic [63:0]  wdata_o;
  logic [7:0]   wstrb_o;
  logic         wlast_o;
  logic         wvalid_o;
  logic         wready_i;
  logic [1:0]   bresp_i;
  logic         bvalid_i;
  logic         bready_o;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  cc_writeback_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_req_valid_i (wb_req_valid_i),
    .wb_req_ready_o (wb_req_ready_o),
    .wb_addr_i      (wb_addr_i),
    .wb_data_i      (wb_data_i),
    .wb_busy_o      (wb_busy_o),
    .wb_pend_addr_o (wb_pend_addr_o),
    .wb_done_o      (wb_done_o),
    .wb_err_o       (wb_err_o),
    .awaddr_o       (awaddr_o),
    .awlen_o        (awlen_o),
    .awsize_o       (awsize_o),
    .awburst_o      (awburst_o),
    .awvalid_o      (awvalid_o),
    .awready_i      (awready_i),
    .wdata_o        (wdata_o),
    .wstrb_o        (wstrb_o),
    .wlast_o        (wlast_o),
    .wvalid_o       (wvalid_o),
    .wready_i       (wready_i),
    .bresp_i        (bresp_i),
    .bvalid_i       (bvalid_i),
    .bready_o       (bready_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom();
    return l;
  endfunction

  task automatic slave_idle();
    awready_i = 1'b0;
    wready_i  = 1'b0;
    bvalid_i  = 1'b0;
    bresp_i   = 2'b00;
  endtask

  // One write-back as seen from requester and memory side. Called at a
  // negedge; all observation happens at negedges, inputs change there too.
  // w_mode: 0 = wready always 1, 1 = toggling 1-0-1, 2 = random.
  task automatic run_wb(input logic [31:0] addr, input line_t data,
                        input int aw_stall, input int w_mode, input int b_delay,
                        input logic [1:0] bresp, input bit timing,
                        input bit chain_in, input bit chain_out,
                        input logic [31:0] next_addr, input line_t next_data,
                        input int abort_beats);
    logic [63:0] exp_words [8];
    logic [31:0] exp_awaddr;
    logic [25:0] exp_pend;
    logic        exp_err;
    int cyc, beat, aw_wait, b_wait, w_cycles;
    bit aw_hs, b_hs, finished, resp_now, aborted;

    for (int k = 0; k < 8; k++) exp_words[k] = data[64*k +: 64];
    exp_awaddr = addr & 32'hFFFF_FFC0;
    exp_pend   = 26'(addr >> 6);
    exp_err    = (bresp != 2'b00);
    beat = 0; aw_wait = 0; b_wait = 0; w_cycles = 0;
    aw_hs = 1'b0; b_hs = 1'b0; finished = 1'b0; aborted = 1'b0;

    if (chain_in) begin
      @(negedge clk);
    end else begin
      check_eq("req_ready", 64'(wb_req_ready_o), 64'd1);
      wb_req_valid_i = 1'b1;
      wb_addr_i      = addr;
      wb_data_i      = data;
      @(negedge clk);
    end
    wb_req_valid_i = 1'b0;
    wb_addr_i      = $urandom();
    wb_data_i      = rand_line();
    cyc = 1;

    while (!finished && cyc < 400) begin
      check_eq("done", 64'(wb_done_o), 64'(b_hs));
      check_eq("err", 64'(wb_err_o), 64'(b_hs && exp_err));
      if (b_hs) begin
        check_eq("ready_at_done", 64'(wb_req_ready_o), 64'd1);
        check_eq("busy_at_done", 64'(wb_busy_o), 64'd0);
        check_eq("pend_at_done", 64'(wb_pend_addr_o), 64'd0);
        check_eq("beat_count", 64'(beat), 64'd8);
        if (timing) check_eq("done_cycle", 64'(cyc), 64'(11 + b_delay));
        finished = 1'b1;
        slave_idle();
      end else begin
        check_eq("busy", 64'(wb_busy_o), 64'd1);
        check_eq("ready_while_busy", 64'(wb_req_ready_o), 64'd0);
        check_eq("pend_addr", 64'(wb_pend_addr_o), 64'(exp_pend));
        check_eq("w_before_aw", 64'(wvalid_o & ~aw_hs), 64'd0);
        if (!aw_hs) check_eq("awvalid_hold", 64'(awvalid_o), 64'd1);
        if (awvalid_o) begin
          check_eq("awaddr", 64'(awaddr_o), 64'(exp_awaddr));
          check_eq("awlen", 64'(awlen_o), 64'd7);
          check_eq("awsize", 64'(awsize_o), 64'd3);
          check_eq("awburst", 64'(awburst_o), 64'd1);
        end
        if (aw_hs && beat < 8) check_eq("wvalid_hold", 64'(wvalid_o), 64'd1);
        if (wvalid_o) begin
          check_eq("extra_beat", 64'(beat >= 8), 64'd0);
          if (beat < 8) begin
            check_eq("wdata", wdata_o, exp_words[beat]);
            check_eq("wlast", 64'(wlast_o), 64'(beat == 7));
            check_eq("wstrb", 64'(wstrb_o), 64'hFF);
            if (timing) check_eq("beat_cycle", 64'(cyc), 64'(2 + beat));
          end
        end
        resp_now = (beat >= 8);
        check_eq("bready", 64'(bready_o), 64'(resp_now));

        if (abort_beats > 0 && beat == abort_beats) begin
          rst_n = 1'b0;
          slave_idle();
          @(negedge clk);
          check_eq("rst_awvalid", 64'(awvalid_o), 64'd0);
          check_eq("rst_wvalid", 64'(wvalid_o), 64'd0);
          check_eq("rst_bready", 64'(bready_o), 64'd0);
          check_eq("rst_ready", 64'(wb_req_ready_o), 64'd1);
          check_eq("rst_busy", 64'(wb_busy_o), 64'd0);
          check_eq("rst_pend", 64'(wb_pend_addr_o), 64'd0);
          rst_n    = 1'b1;
          finished = 1'b1;
          aborted  = 1'b1;
        end else begin
          awready_i = awvalid_o && (aw_wait >= aw_stall);
          if (awvalid_o) aw_wait++;
          if (awvalid_o && awready_i) aw_hs = 1'b1;
          case (w_mode)
            0:       wready_i = 1'b1;
            1:       wready_i = (w_cycles % 2 == 0);
            default: wready_i = 1'($urandom_range(0, 1));
          endcase
          if (wvalid_o) w_cycles++;
          if (wvalid_o && wready_i) beat++;
          bvalid_i = resp_now && (b_wait >= b_delay);
          bresp_i  = bvalid_i ? bresp : 2'b00;
          if (resp_now) b_wait++;
          if (bready_o && bvalid_i) b_hs = 1'b1;
        end
      end
      if (chain_out && cyc == 3) begin
        wb_req_valid_i = 1'b1;
        wb_addr_i      = next_addr;
        wb_data_i      = next_data;
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    check_eq("finished", 64'(finished), 64'd1);
    if (!finished) slave_idle();
    if (finished && !aborted && !chain_out) begin
      @(negedge clk);
      check_eq("done_pulse_width", 64'(wb_done_o), 64'd0);
      check_eq("err_pulse_width", 64'(wb_err_o), 64'd0);
    end
  endtask

  initial begin
    line_t d1;
    line_t d2;
    logic [31:0] a2;
    int aw_s, w_m, b_d;

    rst_n          = 1'b0;
    wb_req_valid_i = 1'b0;
    wb_addr_i      = 32'd0;
    wb_data_i      = '0;
    slave_idle();
    repeat (3) @(negedge clk);
    check_eq("reset_state_ready", 64'(wb_req_ready_o), 64'd1);
    check_eq("reset_awvalid", 64'(awvalid_o), 64'd0);
    check_eq("reset_wvalid", 64'(wvalid_o), 64'd0);
    check_eq("reset_wlast", 64'(wlast_o), 64'd0);
    check_eq("reset_bready", 64'(bready_o), 64'd0);
    check_eq("reset_done", 64'(wb_done_o), 64'd0);
    check_eq("reset_err", 64'(wb_err_o), 64'd0);
    check_eq("reset_busy", 64'(wb_busy_o), 64'd0);
    check_eq("reset_awaddr", 64'(awaddr_o), 64'd0);
    check_eq("reset_wdata", wdata_o, 64'd0);
    check_eq("reset_wstrb", 64'(wstrb_o), 64'd0);
    check_eq("reset_pend", 64'(wb_pend_addr_o), 64'd0);
    check_eq("reset_awlen", 64'(awlen_o), 64'd7);
    check_eq("reset_awsize", 64'(awsize_o), 64'd3);
    check_eq("reset_awburst", 64'(awburst_o), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 8; k++) d1[64*k +: 64] = 64'hA0A0_0000_0000_0000 | 64'(k);

    // Single write-back, memory always ready.
    run_wb(32'h0001_2345, d1, 0, 0, 0, 2'b00, 1'b1, 1'b0, 1'b0, 32'd0, '0, 0);
    // Backpressure on AW and W.
    run_wb(32'h0001_2345, d1, 3, 1, 0, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, '0, 0);
    // Error response.
    run_wb(32'h0BAD_0040, rand_line(), 0, 0, 0, 2'b10, 1'b1, 1'b0, 1'b0, 32'd0, '0, 0);
    // Busy hazard, second request accepted in the done cycle.
    a2 = 32'h7654_3210;
    d2 = rand_line();
    run_wb(32'h0001_2340, d1, 0, 0, 0, 2'b00, 1'b1, 1'b0, 1'b1, a2, d2, 0);
    run_wb(a2, d2, 0, 0, 0, 2'b00, 1'b0, 1'b1, 1'b0, 32'd0, '0, 0);
    // Reset in DATA after beat 3, then a fresh burst.
    run_wb(32'h1234_5680, rand_line(), 0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, '0, 3);
    run_wb(32'h0000_1FC0, d1, 0, 0, 0, 2'b00, 1'b1, 1'b0, 1'b0, 32'd0, '0, 0);
    // Delayed B response.
    run_wb(32'hCAFE_0000, rand_line(), 0, 0, 4, 2'b00, 1'b1, 1'b0, 1'b0, 32'd0, '0, 0);

    // Randomized bursts.
    for (int n = 0; n < 20; n++) begin
      aw_s = $urandom_range(0, 3);
      w_m  = $urandom_range(0, 2);
      b_d  = $urandom_range(0, 4);
      run_wb($urandom(), rand_line(), aw_s, w_m, b_d, 2'($urandom_range(0, 3)),
             (aw_s == 0 && w_m == 0), 1'b0, 1'b0, 32'd0, '0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/cc_writeback_unit.md
# cc_writeback_unit

Write-back engine on the memory side of the cache controller. It accepts one evicted dirty 512-bit line with its 32-bit address, issues a single AXI INCR write burst (AW, then 8 × 64-bit W beats, then B), and reports completion. It is the transmit counterpart of the R-channel data fill path: the fill path deserializes 8 beats into a line, and this block serializes a line into 8 beats.

## Interface
Parameters:
- LINE_BEATS, 8, beats per line (fixed; 8 × 64 b = 512 b).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- wb_req_valid_i  in  1  eviction request valid.
- wb_req_ready_o  out  1  block can accept a request.
- wb_addr_i  in  32  line address; bits [5:0] are ignored.
- wb_data_i  in  512  line data; word k is at [64k+63:64k].
- wb_busy_o  out  1  a write-back is in flight (any state other than IDLE).
- wb_pend_addr_o  out  26  line address [31:6] of the in-flight write-back, used by the miss path for hazard stalls.
- wb_done_o  out  1  one-cycle completion pulse.
- wb_err_o  out  1  one-cycle pulse together with wb_done_o when bresp ≠ OKAY.
- awaddr_o  out  32, awlen_o  out  4, awsize_o  out  3, awburst_o  out  2, awvalid_o  out  1, awready_i  in  1.
- wdata_o  out  64, wstrb_o  out  8, wlast_o  out  1, wvalid_o  out  1, wready_i  in  1.
- bresp_i  in  2, bvalid_i  in  1, bready_o  out  1.

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - wb_req_ready_o = 1.
  - On wb_req_valid_i & ready: capture {wb_addr_i[31:6], 6'b0} and wb_data_i into registers, clear the beat counter, go to ADDR.
- ADDR:
  - awvalid_o = 1 with awaddr = captured address, awlen = 7, awsize = 3 (8 B), awburst = 2'b01 (INCR).
  - On awready_i, go to DATA.
- DATA:
  - wvalid_o = 1, wdata_o = buffer word[cnt], wstrb_o = 8'hFF, wlast_o = (cnt == 7).
  - On wready_i, cnt increments.
  - On a handshake with cnt == 7, go to RESP. cnt is 3 bits and wraps to 0.
- RESP:
  - bready_o = 1.
  - On bvalid_i, go to IDLE and register wb_done_o = 1 and wb_err_o = (bresp_i ≠ 2'b00) for the next cycle.
- Beat order is word 0 first, ascending. There is no wrap or critical-word-first ordering.
- wb_busy_o = (state ≠ IDLE). wb_pend_addr_o holds the captured address [31:6] while busy and is 0 in IDLE.

## Timing
- Reset values:
  - State IDLE, wb_req_ready_o = 1, all other 1-bit outputs 0.
  - awaddr_o, wdata_o, wstrb_o and wb_pend_addr_o are 0.
  - awlen_o, awsize_o and awburst_o are constants.
- Cycle timeline with memory always ready:
  - Request handshake at edge 0.
  - awvalid in cycle 1.
  - W beats in cycles 2–9; wlast in cycle 9.
  - bready from cycle 10. If bvalid_i is already high in cycle 10, the B handshake occurs in cycle 10.
  - wb_done_o in cycle 11, the same cycle wb_req_ready_o returns to 1.
- Handshake rules:
  - awvalid_o and wvalid_o, once asserted, stay high with stable payload until their ready.
  - No W beat is driven before the AW handshake.
  - bvalid_i outside RESP is ignored; it is not expected.
- Back-to-back requests: the earliest next accept is the wb_done_o cycle. No request is accepted in the B-handshake cycle.
- A request presented while busy is held off (ready = 0). The request data may change freely after capture.
- Wait states:
  - wready_i low stalls cnt.
  - A ready deasserting mid-burst causes no beat skip or repeat.
- Reset mid-burst: immediate return to IDLE with all valids dropped. The memory is reset by the same rst_n, so the truncated burst is acceptable.

## Structure
- Shared package cc_pkg:
  - AXI constants: BURST_INCR, SIZE_8B, RESP_OKAY.
  - LINE_BEATS.
  - Write-back state enum wb_state_t.
  - Line type line_t = logic [511:0].
- One natural sub-module, cc_wb_serializer: 512-bit line register, 3-bit beat counter, 64-bit word mux, and wlast generation. It is driven by load and advance strobes from the FSM in cc_writeback_unit.

## Test plan
- Single write-back, all readies high: addr 0x0001_2345, data word k = 0xA0A0_0000_0000_000k → awaddr 0x0001_2340, awlen 7, 8 beats in order k = 0..7, wlast only on beat 7, wb_done_o in cycle 11, wb_err_o = 0.
- Backpressure: awready held low 3 cycles and wready toggling 1-0-1 → payload stable while stalled, exactly 8 beats with the correct order, no duplicates.
- Error response: bresp = 2'b10 → wb_done_o and wb_err_o pulse together for one cycle.
- Busy hazard: second request while busy → ready = 0, wb_pend_addr_o = 0x0000_048D (for address 0x0001_2340); the second request is accepted in the done cycle and its burst completes correctly.
- Reset in DATA after beat 3 → next cycle awvalid/wvalid/bready = 0, ready = 1; a fresh request then completes normally.
- Delayed B: bvalid_i asserted 5 cycles after wlast → bready held high throughout, done pulses the cycle after the handshake.
